// File: rtl/io_serial_port_pkg.sv
// Shared definitions for the programmed-I/O serial port.
//   IO_WIDTH             : data bits per frame, INPR/OUTR width
//   DEFAULT_CLKS_PER_BIT : default bit period in clk cycles
//   SER_STOP_LEVEL       : line level of the stop bit
//   SER_DBITS            : bits sent/received in the DATA state
//                          (data plus the parity bit when IO_PARITY_EN is set)
//   serial_state_t       : state encoding shared by the TX and RX FSMs
// Optional feature macro: IO_PARITY_EN (even parity bit after the data bits).
package io_serial_port_pkg;

    localparam int IO_WIDTH = 8;
    parameter int DEFAULT_CLKS_PER_BIT = 16;
    parameter logic SER_STOP_LEVEL = 1'b1;

`ifdef IO_PARITY_EN
    localparam int SER_DBITS = IO_WIDTH + 1;
`else
    localparam int SER_DBITS = IO_WIDTH;
`endif

    typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} serial_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [IO_WIDTH-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/io_serial_port_if.sv
// CPU-side programmed-I/O bundle of the serial port.
//   outr_i / out_load_i : byte written by OUT and its one-cycle strobe
//   fgo_o               : transmitter ready for a new byte
//   inpr_o / fgi_o      : received byte and its "unread" flag
//   inp_ack_i           : one-cycle strobe from INP, clears fgi_o / rx_ovr_o
//   rx_ovr_o            : sticky overrun flag
//   frame_err_o         : one-cycle pulse on a bad stop bit
//   par_err_o           : one-cycle pulse on a parity mismatch (IO_PARITY_EN only)
// master = CPU side, slave = device side.
interface io_serial_port_if;
    import io_serial_port_pkg::*;

    logic [IO_WIDTH-1:0] outr_i;
    logic                out_load_i;
    logic                fgo_o;
    logic [IO_WIDTH-1:0] inpr_o;
    logic                fgi_o;
    logic                inp_ack_i;
    logic                rx_ovr_o;
    logic                frame_err_o;
`ifdef IO_PARITY_EN
    logic                par_err_o;

    modport master (output outr_i, out_load_i, inp_ack_i,
                    input  fgo_o, inpr_o, fgi_o, rx_ovr_o, frame_err_o, par_err_o);
    modport slave  (input  outr_i, out_load_i, inp_ack_i,
                    output fgo_o, inpr_o, fgi_o, rx_ovr_o, frame_err_o, par_err_o);
`else
    modport master (output outr_i, out_load_i, inp_ack_i,
                    input  fgo_o, inpr_o, fgi_o, rx_ovr_o, frame_err_o);
    modport slave  (input  outr_i, out_load_i, inp_ack_i,
                    output fgo_o, inpr_o, fgi_o, rx_ovr_o, frame_err_o);
`endif

endinterface

// File: rtl/io_serial_port_rx_deser.sv
// Serial receiver: 2-flop synchroniser, start/data/stop FSM sampling mid-bit,
// optional even-parity check (IO_PARITY_EN).
//   clk, rst_n   : clock, async active-low reset
//   rx_i         : asynchronous serial input, idle high
//   byte_o       : last assembled byte (meaningful while valid_o is high)
//   valid_o      : one-cycle pulse, good frame received
//   frame_err_o  : one-cycle pulse, stop bit sampled low
//   par_err_o    : one-cycle pulse, parity mismatch (IO_PARITY_EN only)
module io_rx_deser
    import io_serial_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_i,
    output logic [IO_WIDTH-1:0] byte_o,
    output logic                valid_o,
`ifdef IO_PARITY_EN
    output logic                par_err_o,
`endif
    output logic                frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(SER_DBITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(SER_DBITS - 1);

    logic                rx_s1, rx_s2, rx_prev;
    serial_state_t       state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [IO_WIDTH-1:0] sh, sh_nxt;
    logic                valid_nxt, ferr_nxt, stop_ok;
`ifdef IO_PARITY_EN
    logic                par_acc, par_acc_nxt, perr_nxt;
`endif

    assign byte_o  = sh;
    assign stop_ok = (rx_s2 == SER_STOP_LEVEL);

    // Synchroniser resets to the idle level so release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SER_IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef IO_PARITY_EN
            par_acc     <= 1'b0;
            par_err_o   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            sh          <= sh_nxt;
            valid_o     <= valid_nxt;
            frame_err_o <= ferr_nxt;
`ifdef IO_PARITY_EN
            par_acc     <= par_acc_nxt;
            par_err_o   <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        sh_nxt    = sh;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef IO_PARITY_EN
        par_acc_nxt = par_acc;
        perr_nxt    = 1'b0;
`endif
        unique case (state)
            SER_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s2 && rx_prev) state_nxt = SER_START;
            end
            SER_START: begin
                // Re-check at mid start bit; a high line means it was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s2 ? SER_IDLE : SER_DATA;
`ifdef IO_PARITY_EN
                    par_acc_nxt = 1'b0;
`endif
                end
            end
            SER_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + 1'b1;
`ifdef IO_PARITY_EN
                    par_acc_nxt = par_acc ^ rx_s2;
                    // The parity bit is accumulated but not shifted into the byte.
                    if (idx != IW'(IO_WIDTH)) sh_nxt = {rx_s2, sh[IO_WIDTH-1:1]};
`else
                    sh_nxt = {rx_s2, sh[IO_WIDTH-1:1]};
`endif
                    if (idx == IDX_LAST) state_nxt = SER_STOP;
                end
            end
            SER_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SER_IDLE;
                    ferr_nxt  = !stop_ok;
`ifdef IO_PARITY_EN
                    perr_nxt  = par_acc;
                    valid_nxt = stop_ok && !par_acc;
`else
                    valid_nxt = stop_ok;
`endif
                end
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/io_serial_port.sv
// Device end of the processor's programmed-I/O port: serialises OUTR onto
// tx_o, deserialises rx_i into INPR, and keeps the FGI/FGO/overrun flags.
//   clk, rst_n : clock; async-assert, sync-release active-low reset
//   cpu        : io_serial_port_if.slave (OUTR/FGO, INPR/FGI, ack, error flags)
//   rx_i       : asynchronous serial input, idle high
//   tx_o       : serial output, idle high
// Frame: start(0), IO_WIDTH data LSB first, [even parity if IO_PARITY_EN], stop(1).
module io_serial_port
    import io_serial_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    io_serial_port_if.slave  cpu,
    input  logic             rx_i,
    output logic             tx_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(SER_DBITS);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SER_DBITS - 1);

    // Reset release is retimed to clk; assertion still acts immediately.
    logic [1:0] rst_pipe;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n_int = rst_pipe[1];

    // ---------------- transmitter ----------------
    serial_state_t       tx_state, tx_state_nxt;
    logic [CW-1:0]       tx_cnt, tx_cnt_nxt;
    logic [IW-1:0]       tx_idx, tx_idx_nxt;
    logic [IO_WIDTH-1:0] tx_sh, tx_sh_nxt;
    logic                tx_line_nxt, tx_bit_end, tx_accept, tx_reload, fgo;
`ifdef IO_PARITY_EN
    logic                tx_par, tx_par_nxt;
`endif

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    // Ready during IDLE and on the final stop-bit cycle, so a load then chains
    // straight into the next start bit.
    assign fgo        = (tx_state == SER_IDLE) || (tx_state == SER_STOP && tx_bit_end);
    assign tx_accept  = cpu.out_load_i && fgo;
    assign cpu.fgo_o  = fgo;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tx_state <= SER_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_o     <= 1'b1;
`ifdef IO_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_o     <= tx_line_nxt;
`ifdef IO_PARITY_EN
            tx_par   <= tx_par_nxt;
`endif
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_idx_nxt   = tx_idx;
        tx_sh_nxt    = tx_sh;
        tx_reload    = 1'b0;
`ifdef IO_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        unique case (tx_state)
            SER_IDLE: begin
                tx_cnt_nxt = '0;
                tx_reload  = tx_accept;
            end
            SER_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = SER_DATA;
                    tx_cnt_nxt   = '0;
                    tx_idx_nxt   = '0;
                end
            end
            SER_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_nxt = '0;
                    tx_idx_nxt = tx_idx + 1'b1;
                    tx_sh_nxt  = tx_sh >> 1;
                    if (tx_idx == IDX_LAST) tx_state_nxt = SER_STOP;
                end
            end
            SER_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = SER_IDLE;
                    tx_reload    = tx_accept;
                end
            end
            default: tx_state_nxt = SER_IDLE;
        endcase

        if (tx_reload) begin
            tx_state_nxt = SER_START;
            tx_cnt_nxt   = '0;
            tx_sh_nxt    = cpu.outr_i;
`ifdef IO_PARITY_EN
            tx_par_nxt   = even_parity(cpu.outr_i);
`endif
        end

        // Line level is registered from the next state to keep tx_o glitch-free.
        tx_line_nxt = 1'b1;
        case (tx_state_nxt)
            SER_START: tx_line_nxt = 1'b0;
            SER_DATA: begin
                tx_line_nxt = tx_sh_nxt[0];
`ifdef IO_PARITY_EN
                if (tx_idx_nxt == IW'(IO_WIDTH)) tx_line_nxt = tx_par_nxt;
`endif
            end
            SER_STOP: tx_line_nxt = SER_STOP_LEVEL;
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    // ---------------- receiver + input flags ----------------
    logic [IO_WIDTH-1:0] rx_byte, inpr_q;
    logic                rx_valid, fgi_q, ovr_q;

    io_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst_n       (rst_n_int),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
`ifdef IO_PARITY_EN
        .par_err_o   (cpu.par_err_o),
`endif
        .frame_err_o (cpu.frame_err_o)
    );

    // A delivery beats a simultaneous ack: the new byte stays unread, but the
    // ack still means the previous byte was consumed, so overrun clears.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            inpr_q <= '0;
            fgi_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else if (rx_valid) begin
            inpr_q <= rx_byte;
            fgi_q  <= 1'b1;
            ovr_q  <= cpu.inp_ack_i ? 1'b0 : (ovr_q | fgi_q);
        end else if (cpu.inp_ack_i) begin
            fgi_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end
    end

    assign cpu.inpr_o   = inpr_q;
    assign cpu.fgi_o    = fgi_q;
    assign cpu.rx_ovr_o = ovr_q;

endmodule

// File: tb/tb_io_serial_port.sv
module tb_io_serial_port;
    import io_serial_port_pkg::*;

    localparam int CPB = 16;
    localparam int W   = IO_WIDTH;
`ifdef IO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NB = W + 2 + (PAR_EN ? 1 : 0);  // bits per frame

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_i = 1'b1;
    logic tx_o;

    io_serial_port_if bus();

    io_serial_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (bus),
        .rx_i  (rx_i),
        .tx_o  (tx_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
`ifdef IO_PARITY_EN
    int perr_seen = 0;
    always @(negedge clk) if (bus.par_err_o === 1'b1) perr_seen++;
`endif
    always @(negedge clk) if (bus.frame_err_o === 1'b1) ferr_seen++;

    // Reference model of the CPU-visible input side.
    logic [W-1:0] m_inpr = '0;
    logic         m_fgi  = 1'b0;
    logic         m_ovr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level of bit i of a frame carrying b.
    function automatic logic frame_bit(input logic [W-1:0] b, input int i,
                                       input logic stop_bit, input logic par_flip);
        if (i == 0) return 1'b0;
        if (i <= W) return b[i-1];
        if (PAR_EN && i == W + 1) return (^b) ^ par_flip;
        return stop_bit;
    endfunction

    // Called just after the load edge of b; checks tx_o and fgo_o every cycle.
    task automatic tx_check(input logic [W-1:0] b, input int ign_at,
                            input bit do_next, input logic [W-1:0] nb);
        for (int k = 0; k < NB * CPB; k++) begin
            chk("tx_bit", tx_o, frame_bit(b, k / CPB, 1'b1, 1'b0));
            chk("fgo", bus.fgo_o, (k == NB * CPB - 1));
            if (k == ign_at) begin
                bus.outr_i = 8'hFF;
                bus.out_load_i = 1'b1;
            end
            if (k == NB * CPB - 1 && do_next) begin
                bus.outr_i = nb;
                bus.out_load_i = 1'b1;
            end
            tick();
            bus.out_load_i = 1'b0;
        end
        if (!do_next) begin
            chk("tx_idle", tx_o, 1'b1);
            chk("fgo_idle", bus.fgo_o, 1'b1);
        end
    endtask

    task automatic tx_load(input logic [W-1:0] b);
        bus.outr_i = b;
        bus.out_load_i = 1'b1;
        tick();
        bus.out_load_i = 1'b0;
    endtask

    task automatic rx_send(input logic [W-1:0] b, input logic stop_bit, input logic par_flip);
        int   k = 0;
        int   rise = -1;
        int   f0 = ferr_seen;
        logic prev_fgi = bus.fgi_o;
        logic good;
`ifdef IO_PARITY_EN
        int   p0 = perr_seen;
`endif
        for (int i = 0; i < NB + 1; i++) begin
            rx_i = (i < NB) ? frame_bit(b, i, stop_bit, par_flip) : 1'b1;
            for (int c = 0; c < (i < NB ? CPB : 8); c++) begin
                tick();
                k++;
                if (!prev_fgi && bus.fgi_o === 1'b1 && rise < 0) rise = k;
                prev_fgi = bus.fgi_o;
            end
        end
        good = stop_bit && !(PAR_EN && par_flip);
        if (good) begin
            if (!m_fgi) chk("rx_latency_ok", (rise >= 150 && rise <= 162), 1'b1);
            if (m_fgi) m_ovr = 1'b1;
            m_inpr = b;
            m_fgi  = 1'b1;
        end
        chk("rx_fgi", bus.fgi_o, m_fgi);
        chk("rx_inpr", bus.inpr_o, m_inpr);
        chk("rx_ovr", bus.rx_ovr_o, m_ovr);
        chk("rx_ferr_pulses", ferr_seen - f0, stop_bit ? 0 : 1);
`ifdef IO_PARITY_EN
        chk("rx_perr_pulses", perr_seen - p0, par_flip ? 1 : 0);
`endif
    endtask

    task automatic ack();
        bus.inp_ack_i = 1'b1;
        tick();
        bus.inp_ack_i = 1'b0;
        m_fgi = 1'b0;
        m_ovr = 1'b0;
        chk("ack_fgi", bus.fgi_o, m_fgi);
        chk("ack_ovr", bus.rx_ovr_o, m_ovr);
        chk("ack_inpr", bus.inpr_o, m_inpr);
    endtask

    initial begin
        logic [W-1:0] r0, r1, r2;
        int f0;

        bus.outr_i = '0;
        bus.out_load_i = 1'b0;
        bus.inp_ack_i = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_fgo", bus.fgo_o, 1'b1);
        chk("rst_fgi", bus.fgi_o, 1'b0);
        chk("rst_inpr", bus.inpr_o, '0);
        chk("rst_ovr", bus.rx_ovr_o, 1'b0);
        chk("rst_ferr", bus.frame_err_o, 1'b0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Directed TX, then three random bytes back to back
        tx_load(8'hA5);
        tx_check(8'hA5, -1, 1'b0, '0);
        r0 = W'($urandom_range(255, 0));
        r1 = W'($urandom_range(255, 0));
        r2 = W'($urandom_range(255, 0));
        tx_load(r0);
        tx_check(r0, -1, 1'b1, r1);
        tx_check(r1, -1, 1'b1, r2);
        tx_check(r2, -1, 1'b0, '0);

        // Directed RX, ack, overrun
        rx_send(8'h3C, 1'b1, 1'b0);
        ack();
        rx_send(8'h11, 1'b1, 1'b0);
        rx_send(8'h22, 1'b1, 1'b0);
        ack();

        // Glitch shorter than half a bit, then a bad stop bit
        f0 = ferr_seen;
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        repeat (40) tick();
        chk("glitch_fgi", bus.fgi_o, 1'b0);
        chk("glitch_ferr", ferr_seen - f0, 0);
        rx_send(8'h55, 1'b0, 1'b0);

        // Random RX frames with random acks and occasional bad stop/parity
        for (int n = 0; n < 8; n++) begin
            rx_send(W'($urandom_range(255, 0)), ($urandom_range(3, 0) != 0),
                    PAR_EN && ($urandom_range(3, 0) == 0));
            if ($urandom_range(1, 0) == 1) ack();
            repeat ($urandom_range(6, 0)) tick();
        end

        // Load while busy is ignored
        tx_load(8'hA5);
        tx_check(8'hA5, 50, 1'b0, '0);

        // TX and RX concurrently
        r0 = W'($urandom_range(255, 0));
        r1 = W'($urandom_range(255, 0));
        tx_load(r0);
        fork
            tx_check(r0, -1, 1'b0, '0);
            rx_send(r1, 1'b1, 1'b0);
        join
        ack();

`ifdef IO_PARITY_EN
        rx_send(8'h07, 1'b1, 1'b1);
        tx_load(8'h07);
        tx_check(8'h07, -1, 1'b0, '0);
`endif

        // Put an unread byte in place, then reset in the middle of both frames
        rx_send(8'h5A, 1'b1, 1'b0);
        tx_load(8'hA5);
        rx_i = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        m_inpr = '0;
        m_fgi  = 1'b0;
        m_ovr  = 1'b0;
        chk("mid_rst_tx", tx_o, 1'b1);
        chk("mid_rst_fgo", bus.fgo_o, 1'b1);
        chk("mid_rst_fgi", bus.fgi_o, 1'b0);
        chk("mid_rst_inpr", bus.inpr_o, '0);
        rx_i = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        f0 = ferr_seen;
        repeat (200) tick();
        chk("post_rst_fgi", bus.fgi_o, 1'b0);
        chk("post_rst_ferr", ferr_seen - f0, 0);
        chk("post_rst_tx", tx_o, 1'b1);
        rx_send(W'($urandom_range(255, 0)), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
